// File: rtl/chain_collector_pkg.sv
// ============================================================================
// Module   : chain_collector_pkg
// Brief    : Shared widths, header nibble and FSM encoding for chain_collector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package chain_collector_pkg;

  localparam int         c_DOUT_W     = 16;
  localparam int         c_CH_W       = 4;
  localparam int         c_SAMPLE_W   = 12;
  localparam logic [3:0] c_HDR_NIBBLE = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/collector_fifo.sv
// ============================================================================
// Module   : collector_fifo
// Brief    : Synchronous first-word-fall-through FIFO with full/empty/level.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module collector_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == DEPTH[AW:0]);
  assign level = r_count;
  assign head  = empty ? '0 : r_mem[r_rd_ptr];

  // A pop frees the head slot in the same cycle, so a push while full still fits
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/chain_collector.sv
// ============================================================================
// Module   : chain_collector
// Brief    : Captures one daisy-chain frame per adc_ready rise into a stream FIFO.
//            Optional frame header word enabled by COLLECTOR_FRAME_HDR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module chain_collector #(
  parameter int BITS_ADC   = 12,
  parameter int NUM_CH     = 16,
  parameter int WIN_LEN    = 34,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          adc_ready,
  input  logic [BITS_ADC:0]             chain_in,
  output logic [15:0]                   dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  input  logic                          clr_status,
  output logic                          frame_done,
  output logic                          frame_err,
  output logic                          ovf,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  import chain_collector_pkg::*;

  localparam int CNT_W = $clog2(NUM_CH + 2) + 1;
  localparam int WIN_W = $clog2(WIN_LEN + 1);

  logic [2:0]             r_z;
  logic                   w_rise;
  state_t                 r_state;
  logic [WIN_W-1:0]       r_win_cnt;
  logic [c_CH_W-1:0]      r_ch_cnt;
  logic [CNT_W-1:0]       r_word_cnt;
  logic                   w_smp_push;
  logic [c_DOUT_W-1:0]    w_smp_data;
  logic                   w_push;
  logic [c_DOUT_W-1:0]    w_push_data;
  logic                   w_pop;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_z <= '0;
    else     r_z <= {r_z[1:0], adc_ready};
  end

  assign w_rise     = r_z[1] & ~r_z[2];
  assign w_smp_push = (r_state == ST_CAPTURE) & ~chain_in[BITS_ADC];
  assign w_smp_data = {r_ch_cnt, chain_in[c_SAMPLE_W-1:0]};

`ifdef COLLECTOR_FRAME_HDR_EN
  logic [c_SAMPLE_W-1:0] r_frame_cnt;
  logic                  w_hdr_push;

  assign w_hdr_push  = (r_state == ST_IDLE) & w_rise;
  assign w_push      = w_hdr_push | w_smp_push;
  assign w_push_data = w_hdr_push ? {c_HDR_NIBBLE, r_frame_cnt} : w_smp_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_frame_cnt <= '0;
    else if (w_hdr_push) r_frame_cnt <= r_frame_cnt + 1'b1;
  end
`else
  assign w_push      = w_smp_push;
  assign w_push_data = w_smp_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_win_cnt  <= '0;
      r_ch_cnt   <= '0;
      r_word_cnt <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (clr_status) frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state    <= ST_CAPTURE;
            r_win_cnt  <= '0;
            r_ch_cnt   <= '0;
            r_word_cnt <= '0;
          end
        end
        ST_CAPTURE: begin
          // ch_cnt wraps as the channel tag; word_cnt saturates for the frame check
          if (w_smp_push) begin
            r_ch_cnt <= r_ch_cnt + 1'b1;
            if (r_word_cnt != '1) r_word_cnt <= r_word_cnt + 1'b1;
          end
          if (r_win_cnt == WIN_W'(WIN_LEN - 1)) begin
            r_state    <= ST_DONE;
            frame_done <= 1'b1;
          end else begin
            r_win_cnt <= r_win_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (r_word_cnt != CNT_W'(NUM_CH)) frame_err <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_pop  = dout_ready;
  assign w_drop = w_push & w_full & ~(w_pop & ~w_empty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (w_drop)          ovf <= 1'b1;
      else if (clr_status) ovf <= 1'b0;
      if (w_rise && (r_state != ST_IDLE)) overrun <= 1'b1;
      else if (clr_status)                overrun <= 1'b0;
    end
  end

  collector_fifo #(
    .WIDTH (c_DOUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (dout),
    .empty     (w_empty),
    .full      (w_full),
    .level     (fifo_level)
  );

  assign dout_valid = ~w_empty;

endmodule

`default_nettype wire
